// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared types for the parking-lot occupancy counter.
//   st_e      : passage-direction FSM states (3-bit encoding)
//   P_00..P_11: sensor patterns written as {sensor_a, sensor_b}
// ---------------------------------------------------------------------------
package contador_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EN_A     = 3'd1,
      EN_AB    = 3'd2,
      EN_B     = 3'd3,
      EX_B     = 3'd4,
      EX_AB    = 3'd5,
      EX_A     = 3'd6,
      WAIT_CLR = 3'd7
   } st_e;

   localparam logic [1:0] P_00 = 2'b00;
   localparam logic [1:0] P_10 = 2'b10;
   localparam logic [1:0] P_01 = 2'b01;
   localparam logic [1:0] P_11 = 2'b11;

endpackage

// File: rtl/detector_sentido.sv
// ---------------------------------------------------------------------------
// detector_sentido
// Quadrature-style decoder of a vehicle's passage direction over the
// street-side (a) and lot-side (b) beams, with a per-state stall timeout.
// Ports:
//   clk_slow  in   1 kHz clock, posedge
//   rst       in   synchronous active-high reset
//   sensor_a  in   street-side beam, 1 = interrupted
//   sensor_b  in   lot-side beam, 1 = interrupted
//   ev_entry  out  high for the single cycle in which an entry closes (00 seen in EN_B)
//   ev_exit   out  high for the single cycle in which an exit closes (00 seen in EX_A)
//   ev_fault  out  high for the single cycle of an illegal transition or timeout
// The events are decoded from the current state and pattern so the parent can
// register its count and pulses on the very edge that samples the closing 00.
// ---------------------------------------------------------------------------
module detector_sentido
   import contador_pkg::*;
#(
   parameter int unsigned TIMEOUT = 32'd5000,
   parameter int unsigned TMR_W   = 32'd13
) (
   input  logic clk_slow,
   input  logic rst,
   input  logic sensor_a,
   input  logic sensor_b,
   output logic ev_entry,
   output logic ev_exit,
   output logic ev_fault
);

   st_e              state_r;
   st_e              state_s;
   logic [TMR_W-1:0] tmr_r;
   logic [TMR_W-1:0] tmr_s;
   logic [1:0]       pat_s;
   logic             timeout_s;

   // Next-state, event and timer decode.
   always_comb begin
      state_s   = state_r;
      ev_entry  = 1'b0;
      ev_exit   = 1'b0;
      ev_fault  = 1'b0;
      pat_s     = {sensor_a, sensor_b};
      timeout_s = (tmr_r == TMR_W'(TIMEOUT - 32'd1));

      // A stalled passage is abandoned regardless of the current pattern.
      if ((state_r != IDLE) && (state_r != WAIT_CLR) && timeout_s) begin
         state_s  = WAIT_CLR;
         ev_fault = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               case (pat_s)
                  P_10:    state_s = EN_A;
                  P_01:    state_s = EX_B;
                  P_11:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = IDLE;
               endcase
            end
            EN_A: begin
               case (pat_s)
                  P_11:    state_s = EN_AB;
                  P_00:    state_s = IDLE;
                  P_01:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = EN_A;
               endcase
            end
            EN_AB: begin
               case (pat_s)
                  P_01:    state_s = EN_B;
                  P_10:    state_s = EN_A;
                  P_00:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = EN_AB;
               endcase
            end
            EN_B: begin
               case (pat_s)
                  P_00:    begin state_s = IDLE; ev_entry = 1'b1; end
                  P_11:    state_s = EN_AB;
                  P_10:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = EN_B;
               endcase
            end
            EX_B: begin
               case (pat_s)
                  P_11:    state_s = EX_AB;
                  P_00:    state_s = IDLE;
                  P_10:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = EX_B;
               endcase
            end
            EX_AB: begin
               case (pat_s)
                  P_10:    state_s = EX_A;
                  P_01:    state_s = EX_B;
                  P_00:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = EX_AB;
               endcase
            end
            EX_A: begin
               case (pat_s)
                  P_00:    begin state_s = IDLE; ev_exit = 1'b1; end
                  P_11:    state_s = EX_AB;
                  P_01:    begin state_s = WAIT_CLR; ev_fault = 1'b1; end
                  default: state_s = EX_A;
               endcase
            end
            WAIT_CLR: begin
               if (pat_s == P_00) begin
                  state_s = IDLE;
               end else begin
                  state_s = WAIT_CLR;
               end
            end
            default: state_s = IDLE;
         endcase
      end

      // Timer measures time spent in the current passage state only.
      if ((state_s != state_r) || (state_s == IDLE) || (state_s == WAIT_CLR)) begin
         tmr_s = '0;
      end else begin
         tmr_s = tmr_r + TMR_W'(1);
      end
   end

   // State and timer registers.
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         state_r <= IDLE;
         tmr_r   <= '0;
      end else begin
         state_r <= state_s;
         tmr_r   <= tmr_s;
      end
   end

endmodule

// File: rtl/contador_ocupacion.sv
// ---------------------------------------------------------------------------
// contador_ocupacion
// Saturating parking-lot occupancy counter driven by the direction decoder.
// Ports:
//   clk_slow      in   1 kHz clock, posedge
//   rst           in   synchronous active-high reset
//   sensor_a      in   debounced street-side beam, 1 = interrupted
//   sensor_b      in   debounced lot-side beam, 1 = interrupted
//   btn_inc       in   (MANUAL_ADJ_EN only) debounced manual +1 button
//   btn_dec       in   (MANUAL_ADJ_EN only) debounced manual -1 button
//   count         out  occupancy, 0..CAPACITY
//   full / empty  out  count == CAPACITY / count == 0
//   entry_pulse   out  accepted entry
//   exit_pulse    out  accepted exit
//   reject_pulse  out  entry while full or exit while empty
//   fault_pulse   out  illegal sensor transition or timeout
// Optional feature macro: MANUAL_ADJ_EN (manual +/- buttons).
// ---------------------------------------------------------------------------
module contador_ocupacion
   import contador_pkg::*;
#(
   parameter int unsigned CAPACITY = 32'd20,
   parameter int unsigned CNT_W    = 32'd5,
   parameter int unsigned TIMEOUT  = 32'd5000,
   parameter int unsigned TMR_W    = 32'd13
) (
   input  logic             clk_slow,
   input  logic             rst,
   input  logic             sensor_a,
   input  logic             sensor_b,
`ifdef MANUAL_ADJ_EN
   input  logic             btn_inc,
   input  logic             btn_dec,
`endif
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             entry_pulse,
   output logic             exit_pulse,
   output logic             reject_pulse,
   output logic             fault_pulse
);

   logic             ev_entry_s;
   logic             ev_exit_s;
   logic             ev_fault_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             at_cap_s;
   logic             at_zero_s;
   logic             ent_p_s;
   logic             ext_p_s;
   logic             rej_p_s;

   detector_sentido #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) u_detector (
      .clk_slow (clk_slow),
      .rst      (rst),
      .sensor_a (sensor_a),
      .sensor_b (sensor_b),
      .ev_entry (ev_entry_s),
      .ev_exit  (ev_exit_s),
      .ev_fault (ev_fault_s)
   );

`ifdef MANUAL_ADJ_EN
   logic inc_q_r;
   logic dec_q_r;
   logic inc_edge_s;
   logic dec_edge_s;

   assign inc_edge_s = btn_inc & ~inc_q_r;
   assign dec_edge_s = btn_dec & ~dec_q_r;

   // Previous button levels for rising-edge detection.
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         inc_q_r <= 1'b0;
         dec_q_r <= 1'b0;
      end else begin
         inc_q_r <= btn_inc;
         dec_q_r <= btn_dec;
      end
   end
`endif

   // Next count and pulse decode; sensor commits take precedence over buttons.
   always_comb begin
      cnt_nxt_s = count;
      ent_p_s   = 1'b0;
      ext_p_s   = 1'b0;
      rej_p_s   = 1'b0;
      at_cap_s  = (count == CNT_W'(CAPACITY));
      at_zero_s = (count == '0);
      if (ev_entry_s) begin
         if (!at_cap_s) begin
            cnt_nxt_s = count + CNT_W'(1);
            ent_p_s   = 1'b1;
         end else begin
            rej_p_s   = 1'b1;
         end
      end else if (ev_exit_s) begin
         if (!at_zero_s) begin
            cnt_nxt_s = count - CNT_W'(1);
            ext_p_s   = 1'b1;
         end else begin
            rej_p_s   = 1'b1;
         end
      end else begin
`ifdef MANUAL_ADJ_EN
         // Simultaneous inc and dec edges fall through to "unchanged".
         if (inc_edge_s && !dec_edge_s && !at_cap_s) begin
            cnt_nxt_s = count + CNT_W'(1);
         end else if (dec_edge_s && !inc_edge_s && !at_zero_s) begin
            cnt_nxt_s = count - CNT_W'(1);
         end else begin
            cnt_nxt_s = count;
         end
`else
         cnt_nxt_s = count;
`endif
      end
   end

   // Output registers; flags decoded from the next count so they track count.
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         entry_pulse  <= 1'b0;
         exit_pulse   <= 1'b0;
         reject_pulse <= 1'b0;
         fault_pulse  <= 1'b0;
      end else begin
         count        <= cnt_nxt_s;
         full         <= (cnt_nxt_s == CNT_W'(CAPACITY));
         empty        <= (cnt_nxt_s == '0);
         entry_pulse  <= ent_p_s;
         exit_pulse   <= ext_p_s;
         reject_pulse <= rej_p_s;
         fault_pulse  <= ev_fault_s;
      end
   end

endmodule

// File: tb/tb_contador_ocupacion.sv
// ---------------------------------------------------------------------------
// tb_contador_ocupacion
// Scoreboard bench: each driven cycle runs a table-driven reference model that
// pushes the expected registered outputs; they are popped and compared one
// cycle later, #1 after the sampling edge.
// ---------------------------------------------------------------------------
module tb_contador_ocupacion;

   localparam int CAP = 20;
   localparam int CW  = 5;
   localparam int TO  = 5000;
   localparam int TW  = 13;

   logic          clk_slow = 1'b0;
   logic          rst      = 1'b1;
   logic          sensor_a = 1'b0;
   logic          sensor_b = 1'b0;
   logic          btn_inc  = 1'b0;
   logic          btn_dec  = 1'b0;
   logic [CW-1:0] count;
   logic          full, empty, entry_pulse, exit_pulse, reject_pulse, fault_pulse;

   contador_ocupacion #(
      .CAPACITY (CAP),
      .CNT_W    (CW),
      .TIMEOUT  (TO),
      .TMR_W    (TW)
   ) dut (
      .clk_slow     (clk_slow),
      .rst          (rst),
      .sensor_a     (sensor_a),
      .sensor_b     (sensor_b),
`ifdef MANUAL_ADJ_EN
      .btn_inc      (btn_inc),
      .btn_dec      (btn_dec),
`endif
      .count        (count),
      .full         (full),
      .empty        (empty),
      .entry_pulse  (entry_pulse),
      .exit_pulse   (exit_pulse),
      .reject_pulse (reject_pulse),
      .fault_pulse  (fault_pulse)
   );

   always #5 clk_slow = ~clk_slow;

   typedef struct packed {
      logic [CW-1:0] cnt;
      logic          full;
      logic          empty;
      logic          ep;
      logic          xp;
      logic          rp;
      logic          fp;
   } exp_t;

   exp_t  sb_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   string scen    = "reset";

   // Reference transition table, state index: 0 IDLE, 1 EN_A, 2 EN_AB, 3 EN_B,
   // 4 EX_B, 5 EX_AB, 6 EX_A, 7 WAIT_CLR; column = pattern {a,b} 00,01,10,11.
   // 8 = fault to WAIT_CLR, 9 = commit entry to IDLE, 10 = commit exit to IDLE.
   int nxt_tbl [8][4] = '{
      '{0, 4, 1, 8},
      '{0, 8, 1, 2},
      '{8, 3, 1, 2},
      '{9, 3, 8, 2},
      '{0, 4, 8, 5},
      '{8, 4, 6, 5},
      '{10, 8, 6, 5},
      '{0, 7, 7, 7}
   };

   int   m_st  = 0;
   int   m_tmr = 0;
   int   m_cnt = 0;
   logic m_inc_q = 1'b0;
   logic m_dec_q = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance the reference model by one sampling edge and queue the expectation.
   task automatic model_step();
      exp_t e;
      int   code;
      int   ns;
      bit   ent, ext, inc_e, dec_e;
      e = '0;
      if (rst) begin
         m_st = 0; m_tmr = 0; m_cnt = 0; m_inc_q = 1'b0; m_dec_q = 1'b0;
      end else begin
         ent = 1'b0; ext = 1'b0;
         inc_e = btn_inc && !m_inc_q;
         dec_e = btn_dec && !m_dec_q;
         m_inc_q = btn_inc;
         m_dec_q = btn_dec;
         if (m_st != 0 && m_st != 7 && m_tmr == TO - 1) code = 8;
         else code = nxt_tbl[m_st][{sensor_a, sensor_b}];
         case (code)
            8:       begin ns = 7; e.fp = 1'b1; end
            9:       begin ns = 0; ent = 1'b1; end
            10:      begin ns = 0; ext = 1'b1; end
            default: ns = code;
         endcase
         m_tmr = (ns != m_st || ns == 0 || ns == 7) ? 0 : m_tmr + 1;
         m_st  = ns;
         if (ent) begin
            if (m_cnt < CAP) begin m_cnt++; e.ep = 1'b1; end
            else e.rp = 1'b1;
         end else if (ext) begin
            if (m_cnt > 0) begin m_cnt--; e.xp = 1'b1; end
            else e.rp = 1'b1;
         end else begin
`ifdef MANUAL_ADJ_EN
            if (inc_e && !dec_e && m_cnt < CAP) m_cnt++;
            else if (dec_e && !inc_e && m_cnt > 0) m_cnt--;
`endif
         end
      end
      e.cnt   = CW'(m_cnt);
      e.full  = (m_cnt == CAP);
      e.empty = (m_cnt == 0);
      sb_q.push_back(e);
   endtask

   // Drive a pattern for n cycles, comparing DUT outputs against the scoreboard.
   task automatic step(input logic [1:0] pat, input logic r, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         {sensor_a, sensor_b} = pat;
         rst = r;
         model_step();
         @(posedge clk_slow);
         #1;
         if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_val(scen, {count, full, empty, entry_pulse, exit_pulse, reject_pulse, fault_pulse}, e);
         end
      end
   endtask

   task automatic entry_seq(input int h);
      step(2'b10, 1'b0, h); step(2'b11, 1'b0, h); step(2'b01, 1'b0, h); step(2'b00, 1'b0, h);
   endtask

   task automatic exit_seq(input int h);
      step(2'b01, 1'b0, h); step(2'b11, 1'b0, h); step(2'b10, 1'b0, h); step(2'b00, 1'b0, h);
   endtask

   int first_flt;

   initial begin
      scen = "reset";
      step(2'b00, 1'b1, 2);
      check_val("reset_state", {count, full, empty}, {5'd0, 1'b0, 1'b1});

      scen = "entry";
      step(2'b00, 1'b0, 3);
      entry_seq(3);
      check_val("entry_count", {27'd0, count}, 32'd1);

      scen = "preload";
      for (int i = 0; i < CAP - 1; i++) entry_seq(1);
      check_val("preload_full", {count, full, empty}, {5'd20, 1'b1, 1'b0});

      scen = "full_reject";
      step(2'b10, 1'b0, 1); step(2'b11, 1'b0, 1); step(2'b01, 1'b0, 1);
      step(2'b00, 1'b0, 1);
      check_val("full_reject", {count, reject_pulse, entry_pulse}, {5'd20, 1'b1, 1'b0});
      step(2'b00, 1'b0, 2);

      scen = "empty_reject";
      step(2'b00, 1'b1, 1);
      step(2'b00, 1'b0, 2);
      exit_seq(3);
      check_val("empty_count", {27'd0, count}, 32'd0);

      scen = "exit";
      entry_seq(2);
      exit_seq(2);
      check_val("exit_count", {count, empty}, {5'd0, 1'b1});

      scen = "backout";
      entry_seq(1);
      step(2'b10, 1'b0, 1); step(2'b11, 1'b0, 1); step(2'b10, 1'b0, 1); step(2'b00, 1'b0, 3);
      check_val("backout_count", {27'd0, count}, 32'd1);

      scen = "illegal";
      step(2'b10, 1'b0, 2); step(2'b01, 1'b0, 1);
      check_val("illegal_fault", {31'd0, fault_pulse}, 32'd1);
      step(2'b01, 1'b0, 3); step(2'b11, 1'b0, 2); step(2'b00, 1'b0, 2);
      entry_seq(1);
      check_val("after_fault", {27'd0, count}, 32'd2);

      scen = "timeout";
      first_flt = 0;
      for (int i = 1; i <= TO + 3; i++) begin
         step(2'b10, 1'b0, 1);
         if (fault_pulse === 1'b1 && first_flt == 0) first_flt = i;
      end
      check_val("timeout_latency", first_flt - 1, TO);
      step(2'b00, 1'b0, 2);
      entry_seq(1);
      check_val("timeout_recover", {27'd0, count}, 32'd3);

      scen = "reset_mid";
      step(2'b00, 1'b1, 1);
      for (int i = 0; i < 7; i++) entry_seq(1);
      check_val("pre_reset_count", {27'd0, count}, 32'd7);
      step(2'b10, 1'b0, 1); step(2'b11, 1'b0, 2);
      step(2'b11, 1'b1, 1);
      check_val("reset_mid", {count, empty, entry_pulse, exit_pulse, reject_pulse, fault_pulse},
                {5'd0, 1'b1, 4'b0000});
      step(2'b11, 1'b0, 2); step(2'b00, 1'b0, 2);

`ifdef MANUAL_ADJ_EN
      scen = "manual";
      step(2'b10, 1'b0, 1); step(2'b11, 1'b0, 1); step(2'b01, 1'b0, 1);
      btn_inc = 1'b1;
      step(2'b00, 1'b0, 1);
      check_val("manual_commit_wins", {27'd0, count}, 32'd1);
      step(2'b00, 1'b0, 2);
      btn_inc = 1'b0; step(2'b00, 1'b0, 1);
      btn_inc = 1'b1; step(2'b00, 1'b0, 1);
      check_val("manual_inc", {27'd0, count}, 32'd2);
      btn_inc = 1'b0; btn_dec = 1'b1; step(2'b00, 1'b0, 1);
      check_val("manual_dec", {27'd0, count}, 32'd1);
      btn_dec = 1'b0; step(2'b00, 1'b0, 1);
      btn_inc = 1'b1; btn_dec = 1'b1; step(2'b00, 1'b0, 1);
      check_val("manual_cancel", {27'd0, count}, 32'd1);
      btn_inc = 1'b0; btn_dec = 1'b0; step(2'b00, 1'b0, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/contador_ocupacion.md
Name: contador_ocupacion

Overview:
- Downstream of the two antirebote instances on the entry lane's sensor pair.
- Consumes debounced beam signals sensor_a (street side) and sensor_b (lot side).
- Decodes each vehicle's passage direction with a quadrature-style FSM and maintains a saturating occupancy count with full/empty flags and per-event pulses.
- Sits in the clk_slow (1 kHz) domain and feeds the display/indicator logic.

Parameters:
- CAPACITY, 20, number of spaces; count never exceeds this value.
- CNT_W, 5, width of count; must satisfy 2**CNT_W > CAPACITY.
- TIMEOUT, 5000, clk_slow cycles allowed in any non-idle FSM state before abort (5 s).
- TMR_W, 13, width of the timeout counter; must satisfy 2**TMR_W > TIMEOUT.

Ports:
- clk_slow  in  1  single clock, 1 kHz; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- sensor_a  in  1  debounced street-side beam, 1 = interrupted.
- sensor_b  in  1  debounced lot-side beam, 1 = interrupted.
- count  out  CNT_W  current occupancy, registered.
- full  out  1  high when count == CAPACITY.
- empty  out  1  high when count == 0.
- entry_pulse  out  1  one-cycle pulse on each accepted entry.
- exit_pulse  out  1  one-cycle pulse on each accepted exit.
- reject_pulse  out  1  one-cycle pulse on entry while full, or exit while empty.
- fault_pulse  out  1  one-cycle pulse on illegal sensor transition or timeout.

Behaviour:
- Reset: rst sampled on posedge clk_slow, synchronous, active-high.
  - Returns the FSM to IDLE and clears count and the timer.
  - Sets count=0, empty=1, full=0 and drives all pulse outputs to 0.
  - Applies mid-passage with no event emitted and overrides every other input that cycle.
- Inputs: sensor_a and sensor_b are already synchronous to clk_slow, so there is no extra synchronizer. Sensor pattern is written {a,b}.
- FSM states: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLR. A state persists while its pattern holds.
- Entry path:
  - IDLE: 10->EN_A; 01->EX_B; 11->WAIT_CLR with fault.
  - EN_A: 11->EN_AB; 00->IDLE (vehicle backed out, no event); 01->WAIT_CLR with fault.
  - EN_AB: 01->EN_B; 10->EN_A; 00->WAIT_CLR with fault.
  - EN_B: 00->IDLE and commit entry; 11->EN_AB; 10->WAIT_CLR with fault.
- Exit path: mirror image with a and b swapped (EX_B, EX_AB, EX_A); commit exit on EX_A->00.
- WAIT_CLR: stays until pattern 00, then goes to IDLE. No fault or timeout is raised while waiting.
- Timer:
  - Reset to 0 on every state change and held at 0 in IDLE and WAIT_CLR.
  - Increments otherwise; at TIMEOUT-1 the next cycle goes to WAIT_CLR with fault_pulse.
- Commit entry:
  - count<CAPACITY: count+1 and entry_pulse.
  - count==CAPACITY: count unchanged and reject_pulse.
- Commit exit:
  - count>0: count-1 and exit_pulse.
  - count==0: count unchanged and reject_pulse.
- Latency: a pulse is asserted in the cycle after the closing 00 pattern is sampled. count, full and empty update in the same cycle as the pulse.
- Pulse rules: at most one pulse asserted per cycle. Pulses last exactly one cycle.
- Flags: full and empty are registered and decoded from the next count value.
- Arithmetic: unsigned CNT_W-bit; saturating at 0 and CAPACITY; no wrap.

Optional Feature:
- Macro: MANUAL_ADJ_EN.
- With the macro defined:
  - Adds inputs btn_inc and btn_dec, each debounced and active-high.
  - Each input is rising-edge detected internally (one register each).
  - An edge on btn_inc gives +1 with the same saturation; an edge on btn_dec gives -1.
  - No event pulses are generated by manual adjustment.
  - If a sensor commit occurs in the same cycle, the sensor commit wins and the manual edge is dropped.
  - Simultaneous inc and dec edges cancel.
- Without the macro: the ports and logic are absent and count changes only via the FSM.

Decomposition:
- Package contador_pkg holds:
  - the state enum (st_e, 8 values, 3-bit encoding);
  - the pattern constants P_00, P_10, P_01, P_11.
- One natural sub-module, detector_sentido:
  - contains the FSM and timeout counter;
  - outputs one-cycle ev_entry, ev_exit and ev_fault.
- The parent contador_ocupacion holds the saturating counter, flags, reject logic and the optional manual path.

Test Plan:
- Entry sequence 00,10,11,01,00, each held 3 cycles, from reset -> count 0->1 and entry_pulse for 1 cycle; empty drops with the pulse.
- Preload 20 entries, then one more entry sequence -> count stays 20, full=1, reject_pulse=1, no entry_pulse.
- Exit sequence 00,01,11,10,00 with count=0 -> reject_pulse, count=0. After 1 entry, the same exit sequence -> exit_pulse and count=0.
- Aborts:
  - 10,11,10,00 -> no pulses, count unchanged.
  - Direct 10->01 -> fault_pulse, WAIT_CLR until 00.
- Hold 10 for 5000 cycles -> fault_pulse at cycle 5000; then 00 -> IDLE. A following full entry is accepted.
- Assert rst at EN_AB with count=7 -> next cycle count=0, empty=1, no pulses. With MANUAL_ADJ_EN, btn_inc coincident with an entry commit yields count+1 only.
